sal_addr_decoder: RTL and testbench

// - Request-side source of the per-bank request channel: accepts linear byte-address read/write requests.
// - Splits each request into {ba, ra, ca} and drives the bank request channel (bk_*) toward the bank controller.
// - Splits any request that crosses a row boundary into two bank requests, so every bank request hits exactly one row.
// - Sits between the host request queue and the bank controllers' BK_REQ_IF destination.

---
 rtl/sal_addr_decoder.sv | 123 ++++++++++++
 tb/tb_sal_addr_decoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sal_addr_decoder.sv
// Linear byte address -> {ba, ra, ca} bank request decoder; splits row-crossing bursts into two pieces.
// Optional SAL_BANK_XOR_EN: bk_ba = linear ba ^ ra[BA_W-1:0], applied after split math.
module sal_addr_decoder #(
    parameter int ADDR_W = 32,
    parameter int OFS_W  = 2,
    parameter int CA_W   = 10,
    parameter int BA_W   = 2,
    parameter int RA_W   = 13,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ID_W-1:0]   req_id,
    input  logic [LEN_W-1:0]  req_len,
    output logic              bk_valid,
    input  logic              bk_ready,
    output logic              bk_wr,
    output logic [BA_W-1:0]   bk_ba,
    output logic [RA_W-1:0]   bk_ra,
    output logic [CA_W-1:0]   bk_ca,
    output logic [ID_W-1:0]   bk_id,
    output logic [LEN_W-1:0]  bk_len
);
    localparam int RB_W = RA_W + BA_W;
    localparam logic [CA_W:0]   ROW_SZ  = {1'b1, {CA_W{1'b0}}};
    localparam logic [CA_W:0]   CA_ONE  = 1;
    localparam logic [LEN_W-1:0] LEN_ONE = 1;
    localparam logic [RB_W-1:0] RB_ONE  = 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SPLIT} state_t;
    state_t r_state, w_next;

    logic              r_wr, r_split;
    logic [ID_W-1:0]   r_id;
    logic [RB_W-1:0]   r_rb, r_rb2;
    logic [CA_W-1:0]   r_ca;
    logic [LEN_W-1:0]  r_len, r_len2;

    // {ra,ba} is treated as one field so piece 2 carries into the row and wraps at the top.
    logic [CA_W-1:0]  w_ca, w_ca_inv;
    logic [RB_W-1:0]  w_rb, w_rb2;
    logic [CA_W:0]    w_end;
    logic             w_cross, w_accept, w_bk_hs;
    logic [LEN_W-1:0] w_len1, w_len2;
    logic [BA_W-1:0]  w_ba_lin;
    logic             w_unused;

    assign w_ca     = req_addr[OFS_W +: CA_W];
    assign w_rb     = req_addr[OFS_W+CA_W +: RB_W];
    assign w_end    = {1'b0, w_ca} + {{(CA_W+1-LEN_W){1'b0}}, req_len} + CA_ONE;
    assign w_cross  = (w_end > ROW_SZ);
    assign w_ca_inv = ~w_ca;
    assign w_len1   = w_ca_inv[LEN_W-1:0];
    assign w_len2   = req_len - w_len1 - LEN_ONE;
    assign w_rb2    = w_rb + RB_ONE;
    assign w_accept = req_valid & req_ready;
    assign w_bk_hs  = bk_valid & bk_ready;
    assign w_unused = ^{req_addr[ADDR_W-1:OFS_W+CA_W+RB_W], req_addr[OFS_W-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: if (bk_ready) w_next = r_split ? S_SPLIT : S_IDLE;
            S_SPLIT: if (bk_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == S_IDLE) && rst_n;
        bk_valid  = (r_state == S_ISSUE) || (r_state == S_SPLIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= 1'b0;
            r_split <= 1'b0;
            r_id    <= '0;
            r_rb    <= '0;
            r_rb2   <= '0;
            r_ca    <= '0;
            r_len   <= '0;
            r_len2  <= '0;
        end else if (w_accept) begin
            r_wr    <= req_wr;
            r_id    <= req_id;
            r_rb    <= w_rb;
            r_ca    <= w_ca;
            r_split <= w_cross;
            r_len   <= w_cross ? w_len1 : req_len;
            r_len2  <= w_len2;
            r_rb2   <= w_rb2;
        end else if (r_state == S_ISSUE && w_bk_hs && r_split) begin
            r_rb    <= r_rb2;
            r_ca    <= '0;
            r_len   <= r_len2;
            r_split <= 1'b0;
        end
    end

    assign w_ba_lin = r_rb[BA_W-1:0];
    assign bk_wr    = r_wr;
    assign bk_id    = r_id;
    assign bk_ra    = r_rb[BA_W +: RA_W];
    assign bk_ca    = r_ca;
    assign bk_len   = r_len;
`ifdef SAL_BANK_XOR_EN
    assign bk_ba    = w_ba_lin ^ bk_ra[BA_W-1:0];
`else
    assign bk_ba    = w_ba_lin;
`endif
endmodule

// File: tb/tb_sal_addr_decoder.sv
// Bench for sal_addr_decoder: directed table, random requests vs. a row/column model, reset in SPLIT.
module tb_sal_addr_decoder;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_wr = 1'b0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_id = '0, req_len = '0;
    logic        bk_valid, bk_ready = 1'b0, bk_wr;
    logic [1:0]  bk_ba;
    logic [12:0] bk_ra;
    logic [9:0]  bk_ca;
    logic [3:0]  bk_id, bk_len;

    int n_pass = 0, n_tot = 0;

    sal_addr_decoder dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_id(req_id), .req_len(req_len),
        .bk_valid(bk_valid), .bk_ready(bk_ready), .bk_wr(bk_wr),
        .bk_ba(bk_ba), .bk_ra(bk_ra), .bk_ca(bk_ca), .bk_id(bk_id), .bk_len(bk_len)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [12:0] ra;
        logic [1:0]  ba;
        logic [9:0]  ca;
        logic [3:0]  len;
    } piece_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  id;
        logic [3:0]  len;
        int          stall;
        int          n;
        piece_t      p1;
        piece_t      p2;
    } vec_t;

    function automatic void chk(string nm, longint act, longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endfunction

    function automatic logic [1:0] xb(logic [12:0] ra, logic [1:0] ba);
`ifdef SAL_BANK_XOR_EN
        return ba ^ ra[1:0];
`else
        return ba;
`endif
    endfunction

    // Global column index = byte address / 4; a row is 1024 columns, row index = {ra,ba}.
    function automatic void model(logic [31:0] addr, logic [3:0] len,
                                  output int n, output piece_t p1, output piece_t p2);
        int unsigned g, row, col, row2;
        g   = (addr >> 2) % (32'd1 << 25);
        row = g / 1024;
        col = g % 1024;
        p1.ra = 13'(row / 4); p1.ba = 2'(row % 4); p1.ca = 10'(col);
        p2 = '0;
        if (col + len >= 1024) begin
            n = 2;
            p1.len = 4'(1023 - col);
            row2   = (row + 1) % (32'd1 << 15);
            p2.ra  = 13'(row2 / 4); p2.ba = 2'(row2 % 4); p2.ca = '0;
            p2.len = 4'(len - (1024 - col));
        end else begin
            n = 1;
            p1.len = len;
        end
    endfunction

    task automatic chk_piece(string tag, piece_t e, logic wr, logic [3:0] id);
        chk({tag, "/valid"}, bk_valid, 1);
        chk({tag, "/wr"},    bk_wr,    wr);
        chk({tag, "/id"},    bk_id,    id);
        chk({tag, "/ra"},    bk_ra,    e.ra);
        chk({tag, "/ba"},    bk_ba,    xb(e.ra, e.ba));
        chk({tag, "/ca"},    bk_ca,    e.ca);
        chk({tag, "/len"},   bk_len,   e.len);
    endtask

    task automatic run_req(string tag, logic wr, logic [31:0] addr, logic [3:0] id, logic [3:0] len,
                           int stall, int n, piece_t p1, piece_t p2);
        int t = 0;
        piece_t e;
        while (!req_ready && t < 20) begin @(posedge clk); #1; t++; end
        chk({tag, "/rdy_in"}, req_ready, 1);
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_id = id; req_len = len;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int p = 0; p < n; p++) begin
            e = (p == 0) ? p1 : p2;
            chk_piece($sformatf("%s/p%0d", tag, p + 1), e, wr, id);
            chk({tag, "/rdy_busy"}, req_ready, 0);
            bk_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                chk_piece($sformatf("%s/p%0d_hold", tag, p + 1), e, wr, id);
                chk({tag, "/rdy_hold"}, req_ready, 0);
            end
            bk_ready = 1'b1;
            @(posedge clk); #1;
            bk_ready = 1'b0;
        end
        chk({tag, "/vld_done"}, bk_valid, 0);
        chk({tag, "/rdy_done"}, req_ready, 1);
    endtask

    vec_t   tbl[8];
    piece_t z = '0;

    initial begin
        tbl[0] = '{1'b0, 32'h0000_5008, 4'd5, 4'd3, 0, 1, '{13'd1, 2'd1, 10'h002, 4'd3}, z};
        tbl[1] = '{1'b1, 32'h0000_8FF8, 4'd9, 4'd3, 0, 2, '{13'd2, 2'd0, 10'h3FE, 4'd1},
                                                          '{13'd2, 2'd1, 10'h000, 4'd1}};
        tbl[2] = '{1'b0, 32'hFFFF_FFFF, 4'd2, 4'd1, 0, 2, '{13'h1FFF, 2'd3, 10'h3FF, 4'd0},
                                                          '{13'd0, 2'd0, 10'h000, 4'd0}};
        tbl[3] = '{1'b1, 32'h0000_8FF8, 4'd7, 4'd3, 5, 2, '{13'd2, 2'd0, 10'h3FE, 4'd1},
                                                          '{13'd2, 2'd1, 10'h000, 4'd1}};
        tbl[4] = '{1'b0, 32'h0000_0FF0, 4'd1, 4'd3, 0, 1, '{13'd0, 2'd0, 10'h3FC, 4'd3}, z};
        tbl[5] = '{1'b1, 32'h0000_0FF4, 4'd3, 4'd3, 1, 2, '{13'd0, 2'd0, 10'h3FD, 4'd2},
                                                          '{13'd0, 2'd1, 10'h000, 4'd0}};
        tbl[6] = '{1'b0, 32'h0000_3FFC, 4'd15, 4'd15, 0, 2, '{13'd0, 2'd3, 10'h3FF, 4'd0},
                                                            '{13'd1, 2'd0, 10'h000, 4'd14}};
        tbl[7] = '{1'b1, 32'h0000_3FFC, 4'd4, 4'd0, 0, 1, '{13'd0, 2'd3, 10'h3FF, 4'd0}, z};

        #12;
        chk("rst/bk_valid",  bk_valid,  0);
        chk("rst/req_ready", req_ready, 0);
        chk("rst/bk_ra",     bk_ra,     0);
        chk("rst/bk_len",    bk_len,    0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle/req_ready", req_ready, 1);

        for (int i = 0; i < 8; i++)
            run_req($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].id, tbl[i].len,
                    tbl[i].stall, tbl[i].n, tbl[i].p1, tbl[i].p2);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            logic [3:0]  ln, id;
            logic        w;
            int          n;
            piece_t      p1, p2;
            a  = $urandom;
            if (i % 3 == 0) a[11:2] = 10'(10'h3F0 + $urandom_range(0, 15));
            ln = 4'($urandom_range(0, 15));
            id = 4'($urandom);
            w  = 1'($urandom);
            model(a, ln, n, p1, p2);
            run_req($sformatf("rnd%0d", i), w, a, id, ln, $urandom_range(0, 2), n, p1, p2);
        end

        // Reset while holding piece 2: it must vanish and never reappear.
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h8FF8; req_id = 4'd6; req_len = 4'd3;
        @(posedge clk); #1;
        req_valid = 1'b0; bk_ready = 1'b1;
        @(posedge clk); #1;
        bk_ready = 1'b0;
        chk("split/bk_valid", bk_valid, 1);
        chk("split/bk_ba",    bk_ba,    xb(13'd2, 2'd1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst/bk_valid",  bk_valid,  0);
        chk("arst/req_ready", req_ready, 0);
        chk("arst/bk_ca",     bk_ca,     0);
        chk("arst/bk_len",    bk_len,    0);
        @(negedge clk); rst_n = 1'b1; bk_ready = 1'b1;
        @(posedge clk); #1;
        chk("post/req_ready", req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post/no_piece2", bk_valid, 0);
        end
        bk_ready = 1'b0;
        run_req("post_req", tbl[0].wr, tbl[0].addr, tbl[0].id, tbl[0].len, 0, 1, tbl[0].p1, z);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
